// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy bits and a clear sequencer; reads are combinational, writes/allocs land at the edge.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined; the default build reads stored state only.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [XLEN-1:0]   mem [NREGS];
    logic [NREGS-1:0]  busy;

    // clr_busy/clr_done are flops so no input can reach them combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= SWEEP;
                        cnt      <= AW'(1);
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt == LAST) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Later ports overwrite earlier ones; the alloc set comes last so it beats a same-cycle write clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else if (clr_busy) begin
            if (state == SWEEP) begin
                mem[cnt]  <= '0;
                busy[cnt] <= 1'b0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && waddr[w*AW +: AW] != '0) begin
                    mem[waddr[w*AW +: AW]]  <= wdata[w*XLEN +: XLEN];
                    busy[waddr[w*AW +: AW]] <= 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) begin
                busy[alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd_d;
        logic            rd_b;

        assign ra = raddr[r*AW +: AW];

        always_comb begin
            rd_d = mem[ra];
            rd_b = busy[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && !clr_busy && ra != '0 && waddr[w*AW +: AW] == ra) begin
                    rd_d = wdata[w*XLEN +: XLEN];
                    rd_b = alloc_en && (alloc_addr == ra);
                end
            end
`endif
        end

        assign rdata[r*XLEN +: XLEN] = rd_d;
        assign rbusy[r]              = rd_b;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reference model plus a queue of expected read results.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] d;
        logic            b;
    } exp_t;

    exp_t            sb [$];
    logic [XLEN-1:0] m_mem [NREGS];
    logic            m_busy [NREGS];
    logic            m_frozen;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_zero();
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        we       = '0;
        alloc_en = 1'b0;
        clr_req  = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
        we[p]                = 1'b1;
        waddr[p*AW +: AW]    = AW'(a);
        wdata[p*XLEN +: XLEN] = d;
    endtask

    task automatic alloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = AW'(a);
    endtask

    // Model captures the inputs held across the rising edge
    task automatic tick();
        @(posedge clk);
        if (!m_frozen) begin
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && waddr[p*AW +: AW] != '0) begin
                    m_mem[waddr[p*AW +: AW]]  = wdata[p*XLEN +: XLEN];
                    m_busy[waddr[p*AW +: AW]] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    // Even ports read a0, odd ports read a1
    task automatic rd(input string tag, input int a0, input int a1);
        exp_t e;
        int   a;
        for (int r = 0; r < NRD; r++) begin
            a = (r % 2 == 0) ? a0 : a1;
            raddr[r*AW +: AW] = AW'(a);
            e.d = m_mem[a];
            e.b = m_busy[a];
            sb.push_back(e);
        end
        #1;
        for (int r = 0; r < NRD; r++) begin
            e = sb.pop_front();
            chk($sformatf("%s_d%0d", tag, r), 64'(rdata[r*XLEN +: XLEN]), 64'(e.d));
            chk($sformatf("%s_b%0d", tag, r), 64'(rbusy[r]), 64'(e.b));
        end
    endtask

    task automatic rd_all(input string tag);
        for (int a = 0; a < NREGS; a += 2) begin
            rd(tag, a, a + 1);
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        int bad_cnt;

        rst_n      = 1'b0;
        raddr      = '0;
        waddr      = '0;
        wdata      = '0;
        alloc_addr = '0;
        m_frozen   = 1'b0;
        idle();
        m_zero();
        repeat (2) @(negedge clk);
        rd("rst_state", 1, 31);
        chk("rst_clr_busy", 64'(clr_busy), 64'd0);
        chk("rst_clr_done", 64'(clr_done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Populate, then pull reset mid-cycle
        wr(0, 1, 32'h0000_1111);
        wr(1, 2, 32'h0000_2222);
        alloc(3);
        tick();
        idle();
        rd("pre_rst", 1, 2);
        rst_n = 1'b0;
        m_zero();
        #1;
        rd("async_rst", 1, 2);
        rd("async_rst3", 3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        wr(0, 0, 32'hDEAD_BEEF);
        alloc(0);
        tick();
        idle();
        rd("reg0", 0, 0);
        tick();

        wr(0, 5, 32'h1111_1111);
        wr(1, 5, 32'h2222_2222);
        tick();
        idle();
        rd("wr_conflict", 5, 5);
        chk("wr_conflict_val", 64'(rdata[XLEN +: XLEN]), 64'h2222_2222);
        tick();

        wr(1, 6, 32'h0000_0066);
        wr(0, 8, 32'h0000_0088);
        tick();
        idle();
        rd("two_regs", 6, 8);
        tick();

        alloc(7);
        tick();
        idle();
        rd("alloc7", 7, 6);
        chk("alloc7_busy", 64'(rbusy[0]), 64'd1);
        tick();
        wr(0, 7, 32'h0000_0077);
        alloc(7);
        tick();
        idle();
        rd("wr_alloc7", 7, 7);
        chk("wr_alloc7_busy", 64'(rbusy[1]), 64'd1);
        tick();
        wr(1, 7, 32'h0000_0078);
        tick();
        idle();
        rd("wr_only7", 7, 7);
        chk("wr_only7_busy", 64'(rbusy[0]), 64'd0);
        tick();

        // Bypass: new data for reg 3 driven while reading it
        wr(0, 3, 32'hAAAA_0003);
        tick();
        idle();
        wr(0, 3, 32'h1234_5678);
`ifdef REGFILE_BYPASS_EN
        wr(1, 4, 32'h0000_0044);
        alloc(4);
        raddr[0 +: AW]  = AW'(3);
        raddr[AW +: AW] = AW'(4);
        #1;
        chk("byp_same_d", 64'(rdata[0 +: XLEN]), 64'h1234_5678);
        chk("byp_same_b", 64'(rbusy[0]), 64'd0);
        chk("byp_alloc_d", 64'(rdata[XLEN +: XLEN]), 64'h0000_0044);
        chk("byp_alloc_b", 64'(rbusy[1]), 64'd1);
`else
        rd("byp_old", 3, 3);
`endif
        tick();
        idle();
        rd("byp_new", 3, 4);
        tick();

        // Sweep
        for (int a = 1; a < NREGS; a += 2) begin
            wr(0, a, 32'hA5A5_A5A5);
            if (a + 1 < NREGS) wr(1, a + 1, 32'hA5A5_A5A5);
            alloc(a);
            tick();
            idle();
        end
        rd("filled", 1, NREGS - 1);
        tick();
        clr_req = 1'b1;
        tick();
        clr_req  = 1'b0;
        m_frozen = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int c = 0; c < 4 * NREGS; c++) begin
            #2;
            if (!clr_busy) break;
            busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (c == 3) begin
                wr(0, 9, 32'hFFFF_FFFF);
                alloc(9);
                clr_req = 1'b1;
            end
            tick();
            idle();
        end
        m_frozen = 1'b0;
        m_zero();
        chk("sweep_busy_cycles", 64'(busy_cnt), 64'(NREGS));
        chk("sweep_done_pulses", 64'(done_cnt), 64'd1);
        chk("sweep_done_last", 64'(done_at), 64'(NREGS));
        wr(0, 12, 32'h0000_005A);
        tick();
        idle();
        chk("sweep_no_restart", 64'(clr_busy), 64'd0);
        rd_all("after_sweep");

        // Reset while the sweep counter sits at 10
        wr(0, 10, 32'h0000_0010);
        wr(1, 31, 32'h0000_0031);
        tick();
        idle();
        clr_req = 1'b1;
        tick();
        clr_req  = 1'b0;
        m_frozen = 1'b1;
        repeat (9) tick();
        #2;
        chk("mid_sweep_busy", 64'(clr_busy), 64'd1);
        rst_n = 1'b0;
        m_zero();
        #1;
        chk("mid_rst_busy", 64'(clr_busy), 64'd0);
        chk("mid_rst_done", 64'(clr_done), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        m_frozen = 1'b0;
        bad_cnt  = 0;
        for (int c = 0; c < 2 * NREGS; c++) begin
            #2;
            if (clr_busy || clr_done) bad_cnt++;
            tick();
        end
        chk("no_resume", 64'(bad_cnt), 64'd0);
        rd_all("after_mid_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with per-register scoreboard busy bits and a hardware clear sequencer. Next-generation replacement for the single-write, dual-read CPU register file. Serves superscalar/multi-issue cores (NWR writeback ports, NRD operand ports). Sits between decode/issue (reads, busy allocation) and writeback.

## Interface
- XLEN, 32: data width.
- NREGS, 32: number of registers; power of two, ≥ 4; AW = $clog2(NREGS).
- NRD, 2: read ports.
- NWR, 2: write ports.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  NWR  per-port write enable.
- waddr  in  NWR*AW  write addresses, port i at [i*AW +: AW].
- wdata  in  NWR*XLEN  write data, port i at [i*XLEN +: XLEN].
- raddr  in  NRD*AW  read addresses.
- rdata  out  NRD*XLEN  read data, combinational.
- rbusy  out  NRD  busy bit of each raddr, combinational.
- alloc_en  in  1  set busy bit of alloc_addr.
- alloc_addr  in  AW  register being allocated by issue.
- clr_req  in  1  start clear sweep (single-cycle pulse sufficient).
- clr_busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse at sweep end.

## Operation
- Reset (rst_n low, async): all entries 0, all busy bits 0, FSM IDLE, clr_busy=0, clr_done=0. rdata/rbusy therefore 0.
- Register 0: never written, never busy; rdata=0, rbusy=0 for raddr 0.
- Write: port i with we[i]=1 and waddr≠0 writes wdata at the edge and clears that address's busy bit. Several ports, same address: highest port index wins.
- Allocate: alloc_en with alloc_addr≠0 sets the busy bit. Same-cycle alloc and write to the same address: data written, busy bit ends SET (allocation wins).
- Read: rdata = stored entry, rbusy = stored busy bit; pure function of raddr and state.
- Clear FSM, states IDLE → SWEEP → DONE → IDLE:
  - IDLE: clr_req=1 → SWEEP, counter=1.
  - SWEEP: each cycle zeroes entry[counter] and busy[counter]; counter==NREGS-1 → DONE, else counter+1.
  - DONE: clr_done=1 for one cycle → IDLE.
  - clr_busy=1 in SWEEP and DONE.
  - While clr_busy=1: all writes and allocs ignored; clr_req ignored. Reads still return current (partly cleared) contents.
- rst_n low mid-sweep: immediate return to reset state; no sweep resumes.

## Timing
- Write latency: data visible on rdata the cycle after the write edge (one cycle earlier with bypass, see Configuration).
- Busy set/clear visible on rbusy the cycle after the edge.
- Sweep: clr_req sampled at edge k; clr_busy high from k+1 for NREGS cycles (NREGS-1 SWEEP + 1 DONE); clr_done high in the last of those; writes accepted again from edge k+NREGS+1.
- No internal combinational path from inputs to clr_busy/clr_done.

## Configuration
- REGFILE_BYPASS_EN defined: per read port, if any write port has we=1, waddr=raddr≠0 and clr_busy=0 in the current cycle, rdata = that port's wdata (highest index wins) and rbusy=0 unless alloc_en targets the same address in the same cycle (then rbusy=1).
- Undefined: no bypass; rdata/rbusy purely from stored state; no combinational path wdata→rdata.

## Test plan
- Reset: rst_n low mid-cycle with nonzero contents → all rdata=0, rbusy=0, clr_busy=0 immediately; write 0xDEADBEEF to reg 0 → reads 0.
- Write conflict: port0 writes 0x11111111, port1 writes 0x22222222, both to reg 5 → next cycle reg 5 reads 0x22222222 on every read port.
- Scoreboard: alloc reg 7 → rbusy=1 next cycle; same-cycle write+alloc reg 7 → data updated, rbusy stays 1; later write only → rbusy=0.
- Sweep: fill regs 1..NREGS-1 with 0xA5A5A5A5, pulse clr_req → clr_busy high exactly NREGS cycles, clr_done one cycle, all reads 0; write attempted during sweep leaves 0.
- Reset mid-sweep at counter=10 → FSM IDLE, clr_busy=0, no clr_done, all entries 0.
- Bypass (macro on): write 0x12345678 to reg 3 while raddr=3 → rdata=0x12345678 same cycle; macro off → old value same cycle, new value next cycle.
